// File: rtl/irq_ack_initiator_pkg.sv
// ---------------------------------------------------------------------------
// irq_hs_pkg
// Shared types and helpers for the interrupt acknowledge initiator.
//   IRQ_W_DEF      : default width of the irq bus / number of sources
//   IRQ_W_MAX      : widest irq bus the helper function handles
//   irq_hs_state_t : handshake FSM states (IDLE, REQ, REL)
//   onehot_lsb()   : isolates the lowest set bit of a vector
// ---------------------------------------------------------------------------
package irq_hs_pkg;

   localparam int IRQ_W_DEF = 8;
   localparam int IRQ_W_MAX = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } irq_hs_state_t;

   // Two's complement trick: vec & -vec keeps only the lowest set bit,
   // which is exactly "lowest index wins" priority as a one-hot vector.
   function automatic logic [IRQ_W_MAX-1:0] onehot_lsb(input logic [IRQ_W_MAX-1:0] vec);
      return vec & (-vec);
   endfunction

endpackage

// File: rtl/irq_ack_initiator_if.sv
// ---------------------------------------------------------------------------
// irq_ack_initiator_if
// Handshake bundle between an interrupt initiator and its responder.
//   ack : request strobe, initiator -> responder
//   irq : one-hot source being issued, initiator -> responder
//   gnt : grant level, responder -> initiator
// Modports: master (initiator side), slave (responder side).
// ---------------------------------------------------------------------------
interface irq_ack_initiator_if
   import irq_hs_pkg::*;
#(
   parameter int IRQ_W = IRQ_W_DEF
) ();

   logic             ack;
   logic [IRQ_W-1:0] irq;
   logic             gnt;

   modport master (output ack, output irq, input gnt);
   modport slave  (input ack, input irq, output gnt);

endinterface

// File: rtl/irq_ack_initiator_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
// Combinational priority encoder: the lowest set index of req wins.
//   req    in  IRQ_W : eligible requests (pending & mask)
//   onehot out IRQ_W : one-hot of the winning request, 0 if none
//   valid  out 1     : at least one request present
// ---------------------------------------------------------------------------
module irq_prio_enc
   import irq_hs_pkg::*;
#(
   parameter int IRQ_W = IRQ_W_DEF
) (
   input  logic [IRQ_W-1:0] req,
   output logic [IRQ_W-1:0] onehot,
   output logic             valid
);

   logic [IRQ_W_MAX-1:0] req_wide;
   logic [IRQ_W_MAX-1:0] oh_wide;
   logic                 unused_hi;

   // Widen to the helper's fixed width; the upper request bits are zero,
   // so the winning bit always lands inside the low IRQ_W bits and the
   // remaining result bits are known to be zero.
   assign req_wide  = IRQ_W_MAX'(req);
   assign oh_wide   = onehot_lsb(req_wide);
   assign onehot    = oh_wide[IRQ_W-1:0];
   assign valid     = |req;
   assign unused_hi = |oh_wide;

endmodule

// File: rtl/irq_ack_initiator.sv
// ---------------------------------------------------------------------------
// irq_ack_initiator
// Initiator end of the gnt/ack/irq handshake. Interrupt sources are latched
// into a pending register, the lowest-index enabled pending source is
// issued one-hot on irq with ack high, and a 4-phase handshake is run
// against the responder's gnt.
//
// Ports
//   clk      in   1     clock, all logic on posedge
//   rst      in   1     asynchronous active-high reset
//   irq_src  in   IRQ_W interrupt request levels, sampled every clock
//   irq_mask in   IRQ_W 1 = source may be issued (masked sources still latch)
//   hs       master     ack/irq out, gnt in
//   pending  out  IRQ_W pending register
//   busy     out  1     handshake in progress (state != IDLE)
//   done     out  1     one-cycle pulse when a handshake completes
//   err      out  1     sticky timeout flag
//
// Optional feature macro: IRQ_TIMEOUT_EN
//   Defined   : REQ/REL abort to IDLE after TIMEOUT_CYC cycles, err set.
//   Undefined : FSM waits indefinitely for gnt, err tied low.
// ---------------------------------------------------------------------------
module irq_ack_initiator
   import irq_hs_pkg::*;
#(
   parameter int IRQ_W       = IRQ_W_DEF,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IRQ_W-1:0]    irq_src,
   input  logic [IRQ_W-1:0]    irq_mask,
   irq_ack_initiator_if.master hs,
   output logic [IRQ_W-1:0]    pending,
   output logic                busy,
   output logic                done,
   output logic                err
);

   irq_hs_state_t    state;
   irq_hs_state_t    state_nxt;
   logic [IRQ_W-1:0] eligible;
   logic [IRQ_W-1:0] sel;
   logic             sel_valid;
   logic [IRQ_W-1:0] irq_q;
   logic [IRQ_W-1:0] clr;
   logic             timeout;

   assign eligible = pending & irq_mask;

   irq_prio_enc #(
      .IRQ_W (IRQ_W)
   ) u_enc (
      .req    (eligible),
      .onehot (sel),
      .valid  (sel_valid)
   );

   // The issued source is cleared only when the responder grants it. The
   // latched irq_q is used rather than the live encoder output so a mask or
   // pending change during REQ cannot clear the wrong bit.
   assign clr = (state == REQ && hs.gnt) ? irq_q : '0;

`ifdef IRQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt;
   logic             abort;

   // Counts cycles spent in the current REQ or REL visit. Any state change
   // restarts it so each phase of the handshake gets the full budget.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (state == IDLE || state_nxt != state) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // The count is compared against one less than the budget so the FSM has
   // spent exactly TIMEOUT_CYC cycles in the phase when it leaves.
   assign timeout = (state != IDLE) && (cnt == CNT_W'(TIMEOUT_CYC - 1));

   // An abort is a timeout that is not pre-empted by the normal gnt edge.
   assign abort = timeout &&
                  ((state == REQ && !hs.gnt) || (state == REL && hs.gnt));

   // err is sticky: once any handshake has been abandoned it stays set
   // until reset so software can see that a responder went silent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (abort) begin
         err <= 1'b1;
      end
   end
`else
   logic unused_cfg;

   assign timeout    = 1'b0;
   assign err        = 1'b0;
   assign unused_cfg = (TIMEOUT_CYC != 0);
`endif

   // Pending register: new requests are OR-ed in after the clear, so a
   // source that is high in its own clearing cycle stays pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~clr) | irq_src;
      end
   end

   // The encoder result is captured while idle so irq stays stable for the
   // whole REQ phase regardless of later pending or mask changes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q <= '0;
      end else if (state == IDLE) begin
         irq_q <= sel;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. A gnt already high while idle is ignored; the REQ
   // exit only looks at gnt sampled in REQ, so a stale grant finishes REQ
   // on its first cycle. The normal gnt edge always beats a timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (sel_valid) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (hs.gnt) begin
               state_nxt = REL;
            end else if (timeout) begin
               state_nxt = IDLE;
            end
         end
         REL: begin
            if (!hs.gnt || timeout) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output decode: ack and irq are only driven in REQ so the responder
   // never sees a stale irq vector while ack is low.
   always_comb begin
      hs.ack = 1'b0;
      hs.irq = '0;
      busy   = 1'b0;
      case (state)
         REQ: begin
            hs.ack = 1'b1;
            hs.irq = irq_q;
            busy   = 1'b1;
         end
         REL: begin
            busy   = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // done marks the cycle after the responder drops gnt in REL, i.e. the
   // first idle cycle after a completed handshake. Aborts leave REL with
   // gnt still high and therefore never pulse done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done <= 1'b0;
      end else begin
         done <= (state == REL) && !hs.gnt;
      end
   end

endmodule

// File: tb/tb_irq_ack_initiator.sv
// ---------------------------------------------------------------------------
// tb_irq_ack_initiator
// Directed bench for irq_ack_initiator. Inputs are driven 1 time unit after
// each rising edge and outputs are sampled at the same point, so every
// expected value below is the state after the edge just taken.
// The timeout scenario follows the IRQ_TIMEOUT_EN macro of the build.
// ---------------------------------------------------------------------------
module tb_irq_ack_initiator;

   logic       clk;
   logic       rst;
   logic [7:0] irq_src;
   logic [7:0] irq_mask;
   logic [7:0] pending;
   logic       busy;
   logic       done;
   logic       err;
   int         checks;
   int         errors;

   irq_ack_initiator_if #(.IRQ_W(8)) hs ();

   irq_ack_initiator #(
      .IRQ_W       (8),
      .TIMEOUT_CYC (10)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .irq_src  (irq_src),
      .irq_mask (irq_mask),
      .hs       (hs),
      .pending  (pending),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the directed sequence ever stalls.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [7:0] src, input logic [7:0] mask, input logic g);
      irq_src  = src;
      irq_mask = mask;
      hs.gnt   = g;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Directed sequence of scenarios.
   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      apply_stimulus(8'h00, 8'hFF, 1'b0);

      // Reset state, then idle with no sources for 20 cycles.
      step();
      check_output("rst_ack", hs.ack, 0);
      check_output("rst_irq", hs.irq, 0);
      check_output("rst_pending", pending, 0);
      check_output("rst_done", done, 0);
      check_output("rst_err", err, 0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         check_output("idle_busy", busy, 0);
      end
      check_output("idle_ack", hs.ack, 0);

      // Single source 0x04, responder grants 3 cycles after ack.
      $display("[TB] single source 0x04");
      apply_stimulus(8'h04, 8'hFF, 1'b0);
      step();
      check_output("s2_pending_set", pending, 8'h04);
      check_output("s2_ack_not_yet", hs.ack, 0);
      apply_stimulus(8'h00, 8'hFF, 1'b0);
      step();
      check_output("s2_ack_high", hs.ack, 1);
      check_output("s2_irq", hs.irq, 8'h04);
      check_output("s2_busy", busy, 1);
      step();
      step();
      step();
      check_output("s2_ack_hold", hs.ack, 1);
      check_output("s2_irq_hold", hs.irq, 8'h04);
      apply_stimulus(8'h00, 8'hFF, 1'b1);
      step();
      check_output("s2_ack_drop", hs.ack, 0);
      check_output("s2_irq_drop", hs.irq, 0);
      check_output("s2_pending_clr", pending, 0);
      check_output("s2_rel_busy", busy, 1);
      check_output("s2_no_early_done", done, 0);
      apply_stimulus(8'h00, 8'hFF, 1'b0);
      step();
      check_output("s2_done", done, 1);
      check_output("s2_idle", busy, 0);
      step();
      check_output("s2_done_pulse", done, 0);

      // Two sources at once: 0x02 first, 0x80 one idle cycle after done.
      $display("[TB] back-to-back 0x82");
      apply_stimulus(8'h82, 8'hFF, 1'b0);
      step();
      check_output("s3_pending", pending, 8'h82);
      apply_stimulus(8'h00, 8'hFF, 1'b0);
      step();
      check_output("s3_first_irq", hs.irq, 8'h02);
      apply_stimulus(8'h00, 8'hFF, 1'b1);
      step();
      check_output("s3_pending_left", pending, 8'h80);
      check_output("s3_ack_drop", hs.ack, 0);
      apply_stimulus(8'h00, 8'hFF, 1'b0);
      step();
      check_output("s3_done", done, 1);
      check_output("s3_gap_ack", hs.ack, 0);
      step();
      check_output("s3_second_ack", hs.ack, 1);
      check_output("s3_second_irq", hs.irq, 8'h80);
      apply_stimulus(8'h00, 8'hFF, 1'b1);
      step();
      check_output("s3_pending_clr", pending, 0);
      apply_stimulus(8'h00, 8'hFF, 1'b0);
      step();
      check_output("s3_done2", done, 1);

      // Masked source latches but is not issued until unmasked.
      $display("[TB] masked source 0x01");
      apply_stimulus(8'h01, 8'hFE, 1'b0);
      step();
      check_output("s4_pending", pending, 8'h01);
      apply_stimulus(8'h00, 8'hFE, 1'b0);
      step();
      step();
      check_output("s4_masked_ack", hs.ack, 0);
      check_output("s4_masked_busy", busy, 0);
      check_output("s4_pending_kept", pending, 8'h01);
      apply_stimulus(8'h00, 8'hFF, 1'b0);
      step();
      check_output("s4_unmask_ack", hs.ack, 1);
      check_output("s4_unmask_irq", hs.irq, 8'h01);

      // Source 0 re-asserted in its clearing cycle stays pending.
      $display("[TB] set wins over clear");
      apply_stimulus(8'h01, 8'hFF, 1'b1);
      step();
      check_output("s5_set_wins", pending, 8'h01);
      check_output("s5_ack_drop", hs.ack, 0);
      apply_stimulus(8'h00, 8'hFF, 1'b0);
      step();
      check_output("s5_done", done, 1);
      step();
      check_output("s5_reissue_ack", hs.ack, 1);
      check_output("s5_reissue_irq", hs.irq, 8'h01);
      apply_stimulus(8'h00, 8'h00, 1'b0);
      step();
      check_output("s5_mask_in_req", hs.irq, 8'h01);
      apply_stimulus(8'h00, 8'h00, 1'b1);
      step();
      check_output("s5_pending_clr", pending, 0);
      apply_stimulus(8'h00, 8'hFF, 1'b0);
      step();
      check_output("s5_done2", done, 1);

      // gnt already high while idle: REQ completes on its first cycle.
      $display("[TB] stale gnt");
      apply_stimulus(8'h10, 8'hFF, 1'b1);
      step();
      check_output("stale_idle", busy, 0);
      check_output("stale_pending", pending, 8'h10);
      apply_stimulus(8'h00, 8'hFF, 1'b1);
      step();
      check_output("stale_ack", hs.ack, 1);
      check_output("stale_irq", hs.irq, 8'h10);
      step();
      check_output("stale_rel_ack", hs.ack, 0);
      check_output("stale_pending_clr", pending, 0);
      apply_stimulus(8'h00, 8'hFF, 1'b0);
      step();
      check_output("stale_done", done, 1);

      // gnt never arrives for source 0x08.
      $display("[TB] no grant for 0x08");
      apply_stimulus(8'h08, 8'hFF, 1'b0);
      step();
      apply_stimulus(8'h00, 8'hFF, 1'b0);
      step();
      check_output("to_ack_high", hs.ack, 1);
`ifdef IRQ_TIMEOUT_EN
      for (int i = 0; i < 9; i++) begin
         step();
      end
      check_output("to_ack_last", hs.ack, 1);
      check_output("to_err_not_yet", err, 0);
      step();
      check_output("to_ack_abort", hs.ack, 0);
      check_output("to_irq_abort", hs.irq, 0);
      check_output("to_err_set", err, 1);
      check_output("to_pending_kept", pending, 8'h08);
      check_output("to_no_done", done, 0);
      check_output("to_idle", busy, 0);
      step();
      check_output("to_reissue", hs.irq, 8'h08);
      check_output("to_err_sticky", err, 1);
`else
      for (int i = 0; i < 50; i++) begin
         step();
      end
      check_output("nto_ack_held", hs.ack, 1);
      check_output("nto_irq_held", hs.irq, 8'h08);
      check_output("nto_err", err, 0);
`endif

      // Asynchronous reset in the middle of REQ.
      $display("[TB] reset mid-handshake");
      rst = 1'b1;
      #1;
      check_output("mid_rst_ack", hs.ack, 0);
      check_output("mid_rst_irq", hs.irq, 0);
      check_output("mid_rst_pending", pending, 0);
      check_output("mid_rst_busy", busy, 0);
      check_output("mid_rst_err", err, 0);
      step();
      rst = 1'b0;
      step();
      check_output("post_rst_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
